// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller slice: request codes, hall-call
// button indices, the scheduler state encoding and the index<->code mapping.
package lift_pkg;

  localparam int unsigned N_CALLS = 6;

  // Request codes as seen on the lift FSM din input
  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_1U   = 3'b001;
  localparam logic [2:0] C_2U   = 3'b010;
  localparam logic [2:0] C_3U   = 3'b011;
  localparam logic [2:0] C_2D   = 3'b110;
  localparam logic [2:0] C_3D   = 3'b111;
  localparam logic [2:0] C_4D   = 3'b100;

  // Hall-call button bit positions
  localparam int unsigned B_1U = 0;
  localparam int unsigned B_2U = 1;
  localparam int unsigned B_3U = 2;
  localparam int unsigned B_2D = 3;
  localparam int unsigned B_3D = 4;
  localparam int unsigned B_4D = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } sched_state_t;

  function automatic logic [2:0] idx2code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = C_1U;
      3'd1:    code = C_2U;
      3'd2:    code = C_3U;
      3'd3:    code = C_2D;
      3'd4:    code = C_3D;
      3'd5:    code = C_4D;
      default: code = C_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] code2idx(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      C_1U:    idx = 3'd0;
      C_2U:    idx = 3'd1;
      C_3U:    idx = 3'd2;
      C_2D:    idx = 3'd3;
      C_3D:    idx = 3'd4;
      C_4D:    idx = 3'd5;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/lift_req_sched_if.sv
// Button/lamp and lift-FSM handshake bundle around the request scheduler.
// master = scheduler side, slave = buttons/lamps and lift FSM side.
interface lift_req_sched_if;
  import lift_pkg::*;

  logic [N_CALLS-1:0] btn;
  logic               lift_done;
  logic [2:0]         lift_din;
  logic               lift_q_empty;
  logic [N_CALLS-1:0] lamp;
  logic               tmo;

  modport master (
    input  btn, lift_done,
    output lift_din, lift_q_empty, lamp, tmo
  );

  modport slave (
    output btn, lift_done,
    input  lift_din, lift_q_empty, lamp, tmo
  );

endinterface

// File: rtl/lift_rr_pick.sv
// Combinational 6-way round-robin picker. Searches ptr+1, ptr+2, ... (mod 6)
// and grants the first set request bit.
module lift_rr_pick
  import lift_pkg::*;
(
  input  logic [N_CALLS-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         gnt_idx,
  output logic               gnt_vld
);

  logic [2:0] cand;

  // Walk the candidates farthest-first so the nearest set bit after ptr is
  // the last one written and therefore wins.
  always_comb begin
    gnt_idx = 3'd0;
    gnt_vld = 1'b0;
    cand    = 3'd0;
    for (int k = N_CALLS; k >= 1; k--) begin
      cand = 3'((32'(ptr) + 32'(k)) % N_CALLS);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lift_req_sched.sv
// Hall-call request scheduler. Latches button pulses into a pending set that
// also drives the lamps, offers one call at a time to the lift FSM in
// round-robin order, and retires the call only when the lift acknowledges by
// dropping lift_done. An offer the lift never takes is abandoned after
// ACK_TMO cycles with a one-cycle tmo pulse; the call stays pending.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | nothing offered; wait for a pending call while the lift is done
//   S_ISSUE | granted code on lift_din, waiting for lift_done to fall
//   S_WAIT  | call retired; wait for the lift to report done again
module lift_req_sched
  import lift_pkg::*;
#(
  parameter int unsigned ACK_TMO = 8
) (
  input logic               clk,
  input logic               rst,
  lift_req_sched_if.master  bus
);

  sched_state_t       state;
  logic [N_CALLS-1:0] pend;
  logic [N_CALLS-1:0] clr;
  logic [2:0]         ptr;
  logic [2:0]         iss_idx;
  logic [7:0]         tmo_cnt;
  logic [2:0]         gnt_idx;
  logic               gnt_vld;

  lift_rr_pick u_pick (
    .req     (pend),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.lamp = pend;

  // One-hot clear of the offered call on the acknowledge edge.
  always_comb begin
    clr = '0;
    if (state == S_ISSUE && !bus.lift_done) begin
      clr[iss_idx] = 1'b1;
    end
  end

  // Pending set; a clear beats a press of the same bit on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend | bus.btn) & ~clr;
    end
  end

  // Offer/acknowledge sequencer with registered lift-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      ptr              <= 3'd5;
      iss_idx          <= 3'd0;
      tmo_cnt          <= 8'd0;
      bus.lift_din     <= C_NONE;
      bus.lift_q_empty <= 1'b1;
      bus.tmo          <= 1'b0;
    end else begin
      bus.tmo <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_vld && bus.lift_done) begin
            state            <= S_ISSUE;
            ptr              <= gnt_idx;
            iss_idx          <= gnt_idx;
            tmo_cnt          <= 8'(ACK_TMO);
            bus.lift_din     <= idx2code(gnt_idx);
            bus.lift_q_empty <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (!bus.lift_done) begin
            state            <= S_WAIT;
            bus.lift_din     <= C_NONE;
            bus.lift_q_empty <= 1'b1;
          end else if (tmo_cnt == 8'd1) begin
            // ptr already points at the abandoned call, so the next search
            // starts past it and another pending call gets a turn.
            state            <= S_IDLE;
            bus.tmo          <= 1'b1;
            bus.lift_din     <= C_NONE;
            bus.lift_q_empty <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        S_WAIT: begin
          if (bus.lift_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state            <= S_IDLE;
          bus.lift_din     <= C_NONE;
          bus.lift_q_empty <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lift_req_sched.md
# lift_req_sched

Request scheduler in front of the lift state machine. It latches single-cycle hall-call button pulses into a pending set and drives the button lamps. It picks one pending call with a round-robin policy and presents it to the lift on `lift_din`/`lift_q_empty`, then holds it until the lift drops `lift_done`. The bit is retired only on that acknowledge. It sits between the button/lamp I/O and the lift FSM, and it is the only driver of the FSM's `din` and `qEmpty` inputs.

## Interface
- `ACK_TMO`, default 8: cycles ISSUE waits for `lift_done` to fall before abandoning the issue (range 2..255).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  6  hall-call pulses; index 0..5 = 1U, 2U, 3U, 2D, 3D, 4D.
- `lift_done`  in  1  lift idle and ready for a request.
- `lift_din`  out  3  request code to lift.
- `lift_q_empty`  out  1  to lift `qEmpty`; 1 = nothing offered.
- `lamp`  out  6  pending-call lamps, equal to the pending register.
- `tmo`  out  1  one-cycle pulse when an issue is abandoned.

## Operation
- Request codes:
  - index 0..5 → 3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100.
  - NONE = 3'b000.
- Pending register `pend[5:0]`: `pend <= (pend | btn) & ~clr`.
  - `clr` is one-hot on acknowledge, else 0.
  - Clear wins over a simultaneous press of the same bit; that press is absorbed.
  - Repeat presses of a pending bit have no effect.
- Round-robin pointer `ptr` (0..5) holds the last granted index.
  - Search order is ptr+1, ptr+2, … mod 6.
  - The first set bit is the grant.
  - `ptr` updates to the grant index on IDLE→ISSUE.
- States (all outputs registered):
  - **IDLE**: din = NONE, q_empty = 1.
    - If `pend != 0` and `lift_done == 1`: latch grant index and code, load `tmo_cnt = ACK_TMO`, go to ISSUE.
  - **ISSUE**: din = granted code, q_empty = 0.
    - If `lift_done == 0`: acknowledge. Clear the granted pend bit and go to WAIT.
    - Else if `tmo_cnt == 1`: pulse `tmo`, leave pend unchanged, go to IDLE. `ptr` keeps the new value, so a different call is tried next if one exists.
    - Else decrement `tmo_cnt`.
  - **WAIT**: din = NONE, q_empty = 1.
    - If `lift_done == 1`: go to IDLE.
- Buttons are sampled in every state, including during ISSUE/WAIT.
- Reset state:
  - `pend = 0`, `ptr = 5` (so index 0 wins first), state IDLE, `tmo_cnt = 0`.
  - Outputs: `lift_din = 000`, `lift_q_empty = 1`, `lamp = 0`, `tmo = 0`.
- Reset mid-operation discards pending calls and any in-flight issue. The lift sees q_empty = 1 and NONE on the next cycle.

## Timing
- Press to lamp: `btn` high in cycle n → `lamp` bit set in cycle n+1.
- Issue latency: pend nonzero and `lift_done = 1` sampled at edge e → `lift_din`/`q_empty = 0` valid from e.
  - Minimum press→issue is 2 cycles from the press cycle.
- The lift takes the request at the next edge while its done is high. Its done falls the same edge.
- The scheduler samples done = 0 one edge later. Lamp clears and state → WAIT at that edge.
- Typical ISSUE residency is 2 cycles; `ACK_TMO ≥ 2` is required.
- Back-to-back service: WAIT→IDLE on done high, then IDLE→ISSUE on the next edge if still pending and done.
  - Minimum gap between issues is 2 cycles after done rises.
- `lamp` reflects `pend` combinationally from the register, so there is no extra delay.

## Structure
- Shared package `lift_pkg`:
  - Request code constants (C_1U … C_4D, C_NONE).
  - Index↔code mapping function.
  - Sched state enum (IDLE/ISSUE/WAIT).
  - Button index constants.
  - Shared with the lift FSM and benches.
- Sub-module `lift_rr_pick`: combinational 6-way round-robin picker.
  - Inputs: `req[5:0]`, `ptr[2:0]`.
  - Outputs: `gnt_idx[2:0]`, `gnt_vld`.
  - Unit-tested alone.

## Test plan
- Reset, no buttons, lift_done = 1 for 20 cycles → `lift_din = 000`, `q_empty = 1`, `lamp = 0`, no `tmo`.
- Pulse btn[2] (3U) in cycle 3, lift_done = 1, lift model drops done 1 cycle after q_empty falls → lamp = 000100 in cycle 4, `lift_din = 011` for 2 cycles, lamp clears at ack, state WAIT until done rises.
- Pulse btn = 6'b100001 at once, model always acks → issue order 001 (1U) then 100 (4D). Re-press both → order 001, 100 again (ptr wraps 5→0).
- Press btn[4] during ISSUE of btn[4] on the ack cycle → bit clears and the press is absorbed. Press 1 cycle later → bit sets again and is reissued.
- Hold lift_done = 1 with no ack, ACK_TMO = 8 → ISSUE lasts 8 cycles, `tmo` pulses once, lamp stays set, reissue follows from IDLE.
- Assert rst during WAIT with lamp = 011000 → next cycle lamp = 0, din = 000, q_empty = 1, ptr = 5.
